// File: rtl/instr_queue.sv
// Instruction queue between the host and the fetch/sequencer stage.
// Holds one program at a time. Once the host's last-marked word is accepted,
// further pushes are refused until that word has been fetched. Pops return
// data one cycle after the request, through registered outputs.
//
// Handshake: the host side uses valid/ready. A word transfers on a rising
// edge where host_valid && host_ready. host_ready depends only on queue
// state, never on host_valid. The fetch side is request/response.
// fetch_req is honoured only when the queue is non-empty, and every honoured
// request produces exactly one fetch_valid pulse on the following cycle.
module instr_queue #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             host_valid,
    input  logic [WIDTH-1:0] host_instr,
    input  logic             host_last,
    output logic             host_ready,
    input  logic             fetch_req,
    output logic             fetch_valid,
    output logic [WIDTH-1:0] fetch_instr,
    output logic             fetch_last,
    output logic [PTR_W:0]   count,
    output logic             empty,
    output logic             full,
    output logic             prog_loaded,
    output logic             underflow_err
);

    localparam logic [PTR_W:0] DEPTH_CNT = DEPTH[PTR_W:0];

    // Each entry stores {last, instr}
    logic [WIDTH:0]   mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [WIDTH:0]   rd_word;
    logic             push;
    logic             pop;
    logic             rd_is_end;

    assign empty      = (count == '0);
    assign full       = (count == DEPTH_CNT);
    assign host_ready = !full && !prog_loaded;

    // Flush wins over both sides, so neither transfer takes effect in that cycle
    assign push = host_valid && host_ready && !flush;
    assign pop  = fetch_req && !empty && !flush;

    assign rd_word = mem[rd_ptr];
    // An unmarked END/NOP opcode (000) also terminates the program
    assign rd_is_end = rd_word[WIDTH] || (rd_word[WIDTH-1:WIDTH-3] == 3'b000);

    // Storage write; contents are deliberately left uncleared by reset/flush
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {host_last, host_instr};
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Registered fetch response; data fields hold between pops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_valid <= 1'b0;
            fetch_instr <= '0;
            fetch_last  <= 1'b0;
        end else if (flush) begin
            fetch_valid <= 1'b0;
        end else begin
            fetch_valid <= pop;
            if (pop) begin
                fetch_instr <= rd_word[WIDTH-1:0];
                fetch_last  <= rd_is_end;
            end
        end
    end

    // Program-resident flag and sticky underflow flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prog_loaded   <= 1'b0;
            underflow_err <= 1'b0;
        end else if (flush) begin
            prog_loaded   <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (pop && rd_word[WIDTH]) begin
                prog_loaded <= 1'b0;
            end else if (push && host_last) begin
                prog_loaded <= 1'b1;
            end
            if (fetch_req && empty) begin
                underflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_queue.sv
// Bench for instr_queue: directed vectors, a queue-based reference model
// checked on every falling edge, and literal expectations per scenario.
module tb_instr_queue;

    localparam int DEPTH = 8;
    localparam int WIDTH = 16;
    localparam int PTR_W = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             flush = 1'b0;
    logic             host_valid = 1'b0;
    logic [WIDTH-1:0] host_instr = '0;
    logic             host_last = 1'b0;
    logic             host_ready;
    logic             fetch_req = 1'b0;
    logic             fetch_valid;
    logic [WIDTH-1:0] fetch_instr;
    logic             fetch_last;
    logic [PTR_W:0]   count;
    logic             empty;
    logic             full;
    logic             prog_loaded;
    logic             underflow_err;

    int n_tests = 0;
    int n_fail  = 0;
    logic chk_en = 1'b0;

    instr_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .host_valid(host_valid), .host_instr(host_instr), .host_last(host_last),
        .host_ready(host_ready),
        .fetch_req(fetch_req), .fetch_valid(fetch_valid),
        .fetch_instr(fetch_instr), .fetch_last(fetch_last),
        .count(count), .empty(empty), .full(full),
        .prog_loaded(prog_loaded), .underflow_err(underflow_err)
    );

    // Clock
    always #5 clk = ~clk;

    // Reference model: a plain FIFO of {last, instr}
    logic [WIDTH:0]   m_q [$];
    logic             m_fv = 1'b0;
    logic [WIDTH-1:0] m_fi = '0;
    logic             m_fl = 1'b0;
    logic             m_pl = 1'b0;
    logic             m_uf = 1'b0;
    int               m_sz;
    logic             m_push;
    logic             m_pop;
    logic [WIDTH:0]   m_e;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q.delete();
            m_fv = 1'b0; m_fi = '0; m_fl = 1'b0; m_pl = 1'b0; m_uf = 1'b0;
        end else if (flush) begin
            m_q.delete();
            m_fv = 1'b0; m_pl = 1'b0; m_uf = 1'b0;
        end else begin
            m_sz   = m_q.size();
            m_push = host_valid && (m_sz < DEPTH) && !m_pl;
            m_pop  = fetch_req && (m_sz > 0);
            if (fetch_req && m_sz == 0) m_uf = 1'b1;
            m_fv = m_pop;
            if (m_pop) begin
                m_e  = m_q.pop_front();
                m_fi = m_e[WIDTH-1:0];
                m_fl = m_e[WIDTH] || (m_e[WIDTH-1:WIDTH-3] == 3'b000);
                if (m_e[WIDTH]) m_pl = 1'b0;
            end
            if (m_push) begin
                m_q.push_back({host_last, host_instr});
                if (host_last) m_pl = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Captured fetch responses, for ordering checks
    logic [WIDTH:0] got_q [$];

    // Compare process against the model on every falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_count",       32'(count),         32'(m_q.size()));
            chk("m_empty",       32'(empty),         32'(m_q.size() == 0));
            chk("m_full",        32'(full),          32'(m_q.size() == DEPTH));
            chk("m_host_ready",  32'(host_ready),    32'((m_q.size() < DEPTH) && !m_pl));
            chk("m_prog_loaded", 32'(prog_loaded),   32'(m_pl));
            chk("m_underflow",   32'(underflow_err), 32'(m_uf));
            chk("m_fetch_valid", 32'(fetch_valid),   32'(m_fv));
            chk("m_fetch_instr", 32'(fetch_instr),   32'(m_fi));
            chk("m_fetch_last",  32'(fetch_last),    32'(m_fl));
            if (fetch_valid) got_q.push_back({fetch_last, fetch_instr});
        end
    end

    // Driver: apply inputs for one rising edge, return 2 ns after it
    task automatic step(input logic hv, input logic [WIDTH-1:0] hi, input logic hl,
                        input logic rq, input logic fl);
        host_valid = hv; host_instr = hi; host_last = hl; fetch_req = rq; flush = fl;
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    logic [WIDTH-1:0] t1_w [8] = '{16'h200F, 16'h4000, 16'h201E, 16'h6000,
                                   16'h8000, 16'h2007, 16'hA000, 16'h0000};
    logic [WIDTH-1:0] t3_w [3] = '{16'h2111, 16'h6222, 16'h0000};
    int k;
    logic acc;

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        chk_en = 1'b1;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_ready", 32'(host_ready), 1);
        chk("rst_fv", 32'(fetch_valid), 0);
        chk("rst_fi", 32'(fetch_instr), 0);
        chk("rst_fl", 32'(fetch_last), 0);
        chk("rst_pl", 32'(prog_loaded), 0);
        chk("rst_uf", 32'(underflow_err), 0);

        // Full program of eight words, then eight fetches
        for (int i = 0; i < 8; i++) step(1'b1, t1_w[i], (i == 7), 1'b0, 1'b0);
        chk("t1_count", 32'(count), 8);
        chk("t1_full", 32'(full), 1);
        chk("t1_pl", 32'(prog_loaded), 1);
        chk("t1_ready", 32'(host_ready), 0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, '0, 1'b0, 1'b1, 1'b0);
            chk("t1_fv", 32'(fetch_valid), 1);
            chk("t1_fi", 32'(fetch_instr), 32'(t1_w[i]));
            chk("t1_fl", 32'(fetch_last), 32'(i == 7));
        end
        chk("t1_pl_clr", 32'(prog_loaded), 0);
        idle();
        chk("t1_empty", 32'(empty), 1);
        chk("t1_ready_back", 32'(host_ready), 1);
        chk("t1_fv_off", 32'(fetch_valid), 0);

        // Push blocked while a program is resident
        step(1'b1, 16'h2001, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h2002, 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'h2003, 1'b1, 1'b0, 1'b0);
        chk("t2_count", 32'(count), 3);
        chk("t2_pl", 32'(prog_loaded), 1);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 16'h4000, 1'b0, 1'b0, 1'b0);
            chk("t2_blocked", 32'(count), 3);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 16'h4000, 1'b0, 1'b1, 1'b0);
            chk("t2_drain", 32'(count), 32'(2 - i));
        end
        chk("t2_last_fl", 32'(fetch_last), 1);
        chk("t2_last_fi", 32'(fetch_instr), 32'h2003);
        chk("t2_pl_clr", 32'(prog_loaded), 0);
        step(1'b1, 16'h4000, 1'b0, 1'b0, 1'b0);
        chk("t2_accept", 32'(count), 1);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("t2_pop_fi", 32'(fetch_instr), 32'h4000);
        chk("t2_pop_fl", 32'(fetch_last), 0);
        idle();

        // Unmarked END opcode terminates the program
        for (int i = 0; i < 3; i++) begin
            step(1'b1, t3_w[i], 1'b0, 1'b0, 1'b0);
            chk("t3_pl_push", 32'(prog_loaded), 0);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b0, 1'b1, 1'b0);
            chk("t3_fi", 32'(fetch_instr), 32'(t3_w[i]));
            chk("t3_fl", 32'(fetch_last), 32'(i == 2));
            chk("t3_pl", 32'(prog_loaded), 0);
        end
        idle();

        // Request while empty, then push+request while empty
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("t4_fv", 32'(fetch_valid), 0);
        chk("t4_uf", 32'(underflow_err), 1);
        step(1'b1, 16'h8123, 1'b0, 1'b1, 1'b0);
        chk("t4_nobypass_fv", 32'(fetch_valid), 0);
        chk("t4_nobypass_cnt", 32'(count), 1);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("t4_pop_fv", 32'(fetch_valid), 1);
        chk("t4_pop_fi", 32'(fetch_instr), 32'h8123);
        chk("t4_uf_held", 32'(underflow_err), 1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("t4_uf_flush", 32'(underflow_err), 0);
        idle();

        // Fill, then push and pop every cycle across the pointer wrap
        for (int i = 0; i < 8; i++) step(1'b1, WIDTH'(16'h3000 + i), 1'b0, 1'b0, 1'b0);
        chk("t5_full", 32'(full), 1);
        got_q.delete();
        k = 8;
        for (int i = 0; i < 20; i++) begin
            acc = host_ready;
            step(1'b1, WIDTH'(16'h3000 + k), 1'b0, 1'b1, 1'b0);
            if (acc) k++;
            chk("t5_count_range", 32'((count == 7) || (count == 8)), 1);
        end
        chk("t5_accepted", 32'(k), 27);
        for (int i = 0; i < k - 20; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        idle();
        idle();
        chk("t5_got_size", 32'(got_q.size()), 32'(k));
        for (int i = 0; i < got_q.size(); i++) begin
            chk("t5_order", 32'(got_q[i]), 32'({1'b0, WIDTH'(16'h3000 + i)}));
        end
        chk("t5_empty", 32'(empty), 1);

        // Flush with push and pop presented together
        for (int i = 0; i < 5; i++) step(1'b1, WIDTH'(16'h2001 + i), (i == 4), 1'b0, 1'b0);
        chk("t6_count", 32'(count), 5);
        chk("t6_pl", 32'(prog_loaded), 1);
        step(1'b1, 16'h4444, 1'b0, 1'b1, 1'b1);
        chk("t6_count0", 32'(count), 0);
        chk("t6_empty", 32'(empty), 1);
        chk("t6_fv", 32'(fetch_valid), 0);
        chk("t6_pl0", 32'(prog_loaded), 0);
        step(1'b1, 16'h5555, 1'b0, 1'b0, 1'b0);
        chk("t6_after_push", 32'(count), 1);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("t6_dropped", 32'(fetch_instr), 32'h5555);
        idle();

        // Asynchronous reset mid-stream, with a fetch response in flight
        for (int i = 0; i < 3; i++) step(1'b1, WIDTH'(16'h6001 + i), 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("t7_pre_fv", 32'(fetch_valid), 1);
        host_valid = 1'b0; fetch_req = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("t7_fv", 32'(fetch_valid), 0);
        chk("t7_count", 32'(count), 0);
        chk("t7_empty", 32'(empty), 1);
        chk("t7_ready", 32'(host_ready), 1);
        chk("t7_fi", 32'(fetch_instr), 0);
        chk("t7_fl", 32'(fetch_last), 0);
        chk("t7_pl", 32'(prog_loaded), 0);
        chk("t7_uf", 32'(underflow_err), 0);
        @(posedge clk);
        #2 reset = 1'b0;
        idle();
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_queue.md
Name: instr_queue

Overview:
- Host-facing instruction FIFO that sits directly upstream of the TPU fetch/sequencer stage.
- Replaces the hard-coded instruction memory as the program source.
- The host pushes 16-bit instruction words with a valid/ready handshake and marks the final word of each program. The fetch stage pops words on request with a registered one-cycle response.
- Holds one program at a time: after the final word is accepted, further pushes are blocked until that word has been fetched.

Parameters:
- DEPTH, 8, number of entries; must be a power of two ≥ 2.
- WIDTH, 16, instruction word width (opcode in bits [WIDTH-1:WIDTH-3]).
- PTR_W, 3, log2(DEPTH); pointer width.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of queue contents and state.
- host_valid  input  1  host presents a word.
- host_instr  input  WIDTH  instruction word.
- host_last  input  1  word is the last of the program.
- host_ready  output  1  queue can accept a word this cycle.
- fetch_req  input  1  fetch stage requests the next word.
- fetch_valid  output  1  fetch_instr/fetch_last valid (one-cycle pulse per pop).
- fetch_instr  output  WIDTH  popped word.
- fetch_last  output  1  popped word is end of program.
- count  output  PTR_W+1  current occupancy, 0..DEPTH.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- prog_loaded  output  1  a last-marked word is resident and not yet popped.
- underflow_err  output  1  sticky: fetch_req seen while empty.

Behaviour:
- Reset: already decided — reset reset, asynchronous, active-high; clock clk.
  - On reset: pointers = 0, count = 0, fetch_valid = 0, fetch_instr = 0, fetch_last = 0, prog_loaded = 0, underflow_err = 0.
  - Therefore empty = 1, full = 0, host_ready = 1.
  - Storage array is not cleared.
- Storage: DEPTH x (WIDTH+1) entries, each holding {last, instr}.
- Push:
  - host_ready = !full && !prog_loaded (combinational).
  - A push is accepted when host_valid && host_ready at the clock edge: writes mem[wr_ptr], wr_ptr + 1 (wraps modulo DEPTH), count + 1.
  - If host_last = 1 on the accepted push, prog_loaded is set the next cycle.
- Pop:
  - Effective when fetch_req && !empty at the clock edge. The next cycle, fetch_valid = 1 and fetch_instr/fetch_last = mem[rd_ptr] fields; rd_ptr + 1 (wraps); count - 1.
  - Latency from request to data is exactly 1 cycle.
  - fetch_valid is 0 on every cycle that does not follow an effective pop. fetch_instr/fetch_last hold their last value when fetch_valid = 0.
- fetch_last: asserted with the stored last bit, OR when the opcode field == 3'b000 (NOP/END). This lets an unmarked END also terminate the program.
- prog_loaded: cleared when an entry whose stored last bit = 1 is popped. It reads 0 in the same cycle that entry's fetch_valid is high.
- Empty request: fetch_req while empty does not pop. fetch_valid stays 0 the next cycle, and underflow_err is set sticky until reset or flush.
- No bypass: a push and a pop in the same cycle while empty leaves no pop. The pushed word is fetchable from the following cycle.
- Simultaneous push and pop, non-empty and non-full: both occur and count is unchanged.
- Full: host_ready = 0, so no push occurs; a pop proceeds normally and host_ready returns to 1 the next cycle (unless prog_loaded).
- Flush:
  - Priority over push and pop in the same cycle: pointers and count reset to 0; fetch_valid, prog_loaded and underflow_err reset to 0.
  - A host word presented that cycle is dropped even if host_ready was 1.
- Reset mid-operation: all state returns to reset values immediately. Any in-flight fetch_valid is cancelled.
- count arithmetic: PTR_W+1 bits; never exceeds DEPTH and never underflows below 0.

Test Plan:
- Reset, then push 0x200F, 0x4000, 0x201E, 0x6000, 0x8000, 0x2007, 0xA000 and 0x0000 (last=1) -> count = 8, full = 1, prog_loaded = 1, host_ready = 0. Eight fetch_reqs return the words in order, each 1 cycle later; fetch_last = 1 only on 0x0000; afterwards empty = 1 and host_ready = 1.
- With prog_loaded = 1 and count = 3, hold host_valid = 1 with 0x4000 -> never accepted and count stays 3 until the last word is popped; the push is accepted the cycle after.
- Program of 3 words with host_last = 0, third word 0x0000 -> fetch_last = 1 on the third pop via opcode detect; prog_loaded stays 0 throughout.
- fetch_req while empty -> fetch_valid = 0 the next cycle and underflow_err = 1, held until flush; push plus fetch_req in the same cycle while empty -> no pop, and the word pops on the next request.
- Fill to count 8, then push and pop every cycle for 20 cycles with DEPTH = 8 -> in-order data across pointer wrap; count stays 7/8 per handshake rules; no lost or duplicated word.
- Assert flush with count = 5 alongside host_valid = 1 and fetch_req = 1 -> next cycle count = 0, empty = 1, fetch_valid = 0, prog_loaded = 0; the host word is dropped. Assert reset mid-stream -> all outputs take reset values immediately (asynchronous).
